// File: rtl/umi_packet_splitter.sv
// umi_packet_splitter: upstream stage of the UMI data aggregator.
// Splits eligible UMI packets whose payload exceeds MAXB bytes into consecutive
// packets of at most MAXB bytes. All other traffic passes through unchanged.
// Optional feature macro: UMI_SPLITTER_STATS_EN adds the split_count output.
module umi_packet_splitter #(
    parameter int unsigned CW   = 32,
    parameter int unsigned AW   = 64,
    parameter int unsigned DW   = 64,
    parameter int unsigned MAXB = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready
`ifdef UMI_SPLITTER_STATS_EN
    ,
    output logic [15:0]   split_count
`endif
);
    localparam int unsigned NB      = DW / 8;
    localparam int unsigned LGM     = $clog2(MAXB);
    localparam int unsigned EOM_BIT = 22;
    localparam int unsigned EX_BIT  = 24;

    localparam logic [4:0] OP_READ      = 5'h01;
    localparam logic [4:0] OP_WRITE     = 5'h03;
    localparam logic [4:0] OP_WRPOSTED  = 5'h05;
    localparam logic [4:0] OP_RDMA      = 5'h07;
    localparam logic [4:0] OP_RESP_READ = 5'h02;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic [1:0]    reset_sync;
    logic          reset_done;
    logic [CW-1:0] held_cmd;
    logic [DW-1:0] held_data;
    logic [8:0]    rem;
    logic [8:0]    cur_n;
    logic [15:0]   off;
    logic          last_chunk;
    logic          in_fire;
    logic          out_fire;

    logic [4:0]    in_op;
    logic [2:0]    in_size;
    logic [7:0]    in_len;
    logic [31:0]   in_total;
    logic          op_ok;
    logic          in_split;

    logic [CW-1:0] src_cmd;
    logic [DW-1:0] src_data;
    logic [8:0]    src_rem;
    logic [15:0]   src_off;
    logic [2:0]    src_size;
    logic [8:0]    epc;
    logic          nx_last;
    logic [8:0]    nx_n;
    logic [CW-1:0] nx_cmd;
    logic [DW-1:0] nx_data;

    // Shift the held payload down to the chunk offset and clear bytes past the chunk.
    function automatic logic [DW-1:0] chunk_data(input logic [DW-1:0] d,
                                                 input logic [15:0]   boff,
                                                 input logic [8:0]    n,
                                                 input logic [2:0]    size);
        logic [DW-1:0] s;
        logic [31:0]   nbytes;
        s      = d >> {boff, 3'b000};
        nbytes = 32'(n) << size;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i >= nbytes) s[i*8 +: 8] = 8'h00;
        end
        return s;
    endfunction

    assign reset_done    = reset_sync[1];
    assign umi_out_valid = (state == BUSY);
    assign umi_in_ready  = reset_done & ((state == IDLE) | (umi_out_ready & last_chunk));
    assign in_fire       = umi_in_valid & umi_in_ready;
    assign out_fire      = umi_out_valid & umi_out_ready;

    // Decide at accept whether the incoming packet must be split.
    always_comb begin
        in_op    = umi_in_cmd[4:0];
        in_size  = umi_in_cmd[7:5];
        in_len   = umi_in_cmd[15:8];
        in_total = 32'({1'b0, in_len} + 9'd1) << in_size;
        op_ok    = (in_op == OP_READ) | (in_op == OP_WRITE) | (in_op == OP_WRPOSTED) |
                   (in_op == OP_RDMA) | (in_op == OP_RESP_READ);
        in_split = op_ok & ~umi_in_cmd[EX_BIT] & (32'(in_size) <= LGM) & (in_total > MAXB);
    end

    // Next chunk: first chunk of a new packet on accept, else the following chunk.
    always_comb begin
        src_cmd  = in_fire ? umi_in_cmd  : held_cmd;
        src_data = in_fire ? umi_in_data : held_data;
        src_rem  = in_fire ? (9'(in_len) + 9'd1) : (rem - cur_n);
        src_off  = in_fire ? 16'd0 : (off + 16'(MAXB));
        src_size = src_cmd[7:5];
        epc      = 9'(MAXB >> src_size);
        nx_last  = (src_rem <= epc);
        nx_n     = nx_last ? src_rem : epc;
        nx_cmd   = src_cmd;
        nx_cmd[15:8]    = 8'(nx_n - 9'd1);
        nx_cmd[EOM_BIT] = src_cmd[EOM_BIT] & nx_last;
        nx_data  = chunk_data(src_data, src_off, nx_n, src_size);
    end

    // Input ready is held low for two clocks after reset release.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) reset_sync <= 2'b00;
        else         reset_sync <= {reset_sync[0], 1'b1};
    end

    // Control FSM with registered output holding stage.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state           <= IDLE;
            held_cmd        <= '0;
            held_data       <= '0;
            rem             <= '0;
            cur_n           <= '0;
            off             <= '0;
            last_chunk      <= 1'b0;
            umi_out_cmd     <= '0;
            umi_out_dstaddr <= '0;
            umi_out_srcaddr <= '0;
            umi_out_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) state <= BUSY;
                end
                BUSY: begin
                    if (out_fire && last_chunk && !in_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (in_fire) begin
                held_cmd        <= umi_in_cmd;
                held_data       <= umi_in_data;
                umi_out_dstaddr <= umi_in_dstaddr;
                umi_out_srcaddr <= umi_in_srcaddr;
                off             <= '0;
                if (in_split) begin
                    rem          <= src_rem;
                    cur_n        <= nx_n;
                    last_chunk   <= nx_last;
                    umi_out_cmd  <= nx_cmd;
                    umi_out_data <= nx_data;
                end else begin
                    rem          <= '0;
                    cur_n        <= '0;
                    last_chunk   <= 1'b1;
                    umi_out_cmd  <= umi_in_cmd;
                    umi_out_data <= umi_in_data;
                end
            end else if (out_fire && !last_chunk) begin
                rem             <= src_rem;
                off             <= src_off;
                cur_n           <= nx_n;
                last_chunk      <= nx_last;
                umi_out_cmd     <= nx_cmd;
                umi_out_data    <= nx_data;
                umi_out_dstaddr <= umi_out_dstaddr + AW'(MAXB);
                umi_out_srcaddr <= umi_out_srcaddr + AW'(MAXB);
            end
        end
    end

`ifdef UMI_SPLITTER_STATS_EN
    // Count committed non-last chunks, saturating.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) split_count <= '0;
        else if (out_fire && !last_chunk && (split_count != 16'hFFFF))
            split_count <= split_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_umi_packet_splitter.sv
// tb_umi_packet_splitter: directed and randomized checks of umi_packet_splitter.
module tb_umi_packet_splitter;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [63:0] src;
        logic [63:0] data;
    } pkt_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid;
    pkt_t        in_pkt;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_cmd;
    logic [63:0] out_dst;
    logic [63:0] out_src;
    logic [63:0] out_data;
    logic        out_ready;
`ifdef UMI_SPLITTER_STATS_EN
    logic [15:0] split_count;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    pkt_t exp_q[$];

    always #5 clk = ~clk;

    umi_packet_splitter #(.CW(32), .AW(64), .DW(64), .MAXB(MAXB)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (in_valid),
        .umi_in_cmd      (in_pkt.cmd),
        .umi_in_dstaddr  (in_pkt.dst),
        .umi_in_srcaddr  (in_pkt.src),
        .umi_in_data     (in_pkt.data),
        .umi_in_ready    (in_ready),
        .umi_out_valid   (out_valid),
        .umi_out_cmd     (out_cmd),
        .umi_out_dstaddr (out_dst),
        .umi_out_srcaddr (out_src),
        .umi_out_data    (out_data),
        .umi_out_ready   (out_ready)
`ifdef UMI_SPLITTER_STATS_EN
        ,
        .split_count     (split_count)
`endif
    );

    task automatic chk(input string tag, input logic [223:0] got, input logic [223:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic pkt_t cur_out();
        pkt_t o;
        o.cmd  = out_cmd;
        o.dst  = out_dst;
        o.src  = out_src;
        o.data = out_data;
        return o;
    endfunction

    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] sz,
                                           input logic [7:0] len, input logic eom);
        logic [31:0] c;
        c       = '0;
        c[4:0]  = op;
        c[7:5]  = sz;
        c[15:8] = len;
        c[22]   = eom;
        return c;
    endfunction

    function automatic pkt_t mk_pkt(input logic [31:0] c, input logic [63:0] d,
                                    input logic [63:0] s, input logic [63:0] dat);
        pkt_t p;
        p.cmd  = c;
        p.dst  = d;
        p.src  = s;
        p.data = dat;
        return p;
    endfunction

    // Reference: expected output packets for one accepted input packet.
    task automatic model_push(input pkt_t p);
        int   op, esz, elems, total, epc, nck, ne;
        bit   elig;
        pkt_t o;
        op    = int'(p.cmd[4:0]);
        esz   = 1 << p.cmd[7:5];
        elems = int'(p.cmd[15:8]) + 1;
        total = elems * esz;
        elig  = (op == 1 || op == 3 || op == 5 || op == 7 || op == 2) && !p.cmd[24] &&
                esz <= MAXB && total > MAXB;
        if (!elig) begin
            exp_q.push_back(p);
            return;
        end
        epc = MAXB / esz;
        nck = (elems + epc - 1) / epc;
        for (int k = 0; k < nck; k++) begin
            ne = (elems - k * epc < epc) ? elems - k * epc : epc;
            o = p;
            o.cmd[15:8] = 8'(ne - 1);
            o.cmd[22]   = p.cmd[22] && (k == nck - 1);
            o.dst       = p.dst + 64'(k * MAXB);
            o.src       = p.src + 64'(k * MAXB);
            o.data      = '0;
            for (int j = 0; j < ne * esz; j++) begin
                if (k * MAXB + j < 8) o.data[j*8 +: 8] = p.data[(k*MAXB + j)*8 +: 8];
            end
            exp_q.push_back(o);
        end
    endtask

    // One clock: drive at negedge, check outputs that commit at the next posedge.
    task automatic step(input logic v, input pkt_t p, input logic ordy,
                        input bit auto_exp, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_pkt    = p;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", 224'(exp_q.size() != 0), 224'(1));
            if (exp_q.size() != 0) chk("out_pkt", cur_out(), exp_q.pop_front());
        end
        if (acc && auto_exp) model_push(p);
    endtask

    // Release reset and check the two-clock input-ready delay.
    task automatic reset_release();
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("rel0_in_ready", 224'(in_ready), 224'(0));
        chk("rel0_out_valid", 224'(out_valid), 224'(0));
        @(negedge clk);
        #1;
        chk("rel1_in_ready", 224'(in_ready), 224'(0));
        chk("rel1_out_valid", 224'(out_valid), 224'(0));
        @(negedge clk);
        #1;
        chk("rel2_in_ready", 224'(in_ready), 224'(1));
        chk("rel2_out_valid", 224'(out_valid), 224'(0));
    endtask

    initial begin
        pkt_t        p, q, idle, pend, held;
        bit          acc, have;
        int          guard;
        logic [4:0]  ops [7];
        ops = '{5'h01, 5'h03, 5'h05, 5'h07, 5'h02, 5'h04, 5'h09};
        idle      = '0;
        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_pkt    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 224'(out_valid), 224'(0));
        chk("rst_in_ready", 224'(in_ready), 224'(0));
        chk("rst_out_pkt", cur_out(), 224'(0));
        reset_release();

        // Write size=0 len=7 splits into two 4-byte packets
        p = mk_pkt(mk_cmd(5'h03, 3'd0, 8'd7, 1'b1), 64'h100, 64'h200, 64'h0807060504030201);
        exp_q.push_back(mk_pkt(mk_cmd(5'h03, 3'd0, 8'd3, 1'b0), 64'h100, 64'h200, 64'h04030201));
        exp_q.push_back(mk_pkt(mk_cmd(5'h03, 3'd0, 8'd3, 1'b1), 64'h104, 64'h204, 64'h08070605));
        step(1'b1, p, 1'b1, 1'b0, acc);
        chk("wr_accept", 224'(acc), 224'(1));
        step(1'b0, idle, 1'b1, 1'b0, acc);
        step(1'b0, idle, 1'b1, 1'b0, acc);
        step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("wr_idle_after", 224'(out_valid), 224'(0));
        chk("wr_q_empty", 224'(exp_q.size()), 224'(0));

        // Read size=1 len=2 (6 bytes) splits into len=1 and len=0
        p = mk_pkt(mk_cmd(5'h01, 3'd1, 8'd2, 1'b1), 64'h40, 64'h80, 64'h1122334455667788);
        exp_q.push_back(mk_pkt(mk_cmd(5'h01, 3'd1, 8'd1, 1'b0), 64'h40, 64'h80, 64'h55667788));
        exp_q.push_back(mk_pkt(mk_cmd(5'h01, 3'd1, 8'd0, 1'b1), 64'h44, 64'h84, 64'h3344));
        step(1'b1, p, 1'b1, 1'b0, acc);
        chk("rd_accept", 224'(acc), 224'(1));
        repeat (3) step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("rd_q_empty", 224'(exp_q.size()), 224'(0));

        // Write size=3 len=0 and write_resp len=7 pass bit-identical
        p = mk_pkt(mk_cmd(5'h03, 3'd3, 8'd0, 1'b1) | 32'h0F30_0000, 64'h1000, 64'h2000, 64'hDEADBEEF_CAFEF00D);
        q = mk_pkt(mk_cmd(5'h04, 3'd0, 8'd7, 1'b1) | 32'hA000_0000, 64'h3000, 64'h4000, 64'h0123456789ABCDEF);
        exp_q.push_back(p);
        step(1'b1, p, 1'b1, 1'b0, acc);
        chk("pass_sz3_accept", 224'(acc), 224'(1));
        exp_q.push_back(q);
        step(1'b1, q, 1'b1, 1'b0, acc);
        chk("pass_resp_accept", 224'(acc), 224'(1));
        repeat (2) step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("pass_q_empty", 224'(exp_q.size()), 224'(0));

        // Back-to-back 4-byte writes: one per clock, in_ready stays high
        for (int i = 0; i < 6; i++) begin
            p = mk_pkt(mk_cmd(5'h03, 3'd0, 8'd3, 1'b1), 64'(32'h500 + 32'(i * 4)),
                       64'(32'h900 + 32'(i * 4)), {$urandom, $urandom});
            exp_q.push_back(p);
            step(1'b1, p, 1'b1, 1'b0, acc);
            chk("b2b_accept", 224'(acc), 224'(1));
            if (i > 0) chk("b2b_out_valid", 224'(out_valid), 224'(1));
        end
        step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("b2b_q_empty", 224'(exp_q.size()), 224'(0));

        // Output stall of 5 clocks mid-split
        p = mk_pkt(mk_cmd(5'h05, 3'd0, 8'd15, 1'b1), 64'h7000, 64'h8000, {$urandom, $urandom});
        step(1'b1, p, 1'b1, 1'b1, acc);
        chk("stall_accept", 224'(acc), 224'(1));
        step(1'b0, idle, 1'b1, 1'b0, acc);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            step(1'b0, idle, 1'b0, 1'b0, acc);
            chk("stall_out_valid", 224'(out_valid), 224'(1));
            chk("stall_in_ready", 224'(in_ready), 224'(0));
            chk("stall_hold", cur_out(), held);
        end
        repeat (4) step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("stall_q_empty", 224'(exp_q.size()), 224'(0));

        // Reset asserted during the second chunk
        p = mk_pkt(mk_cmd(5'h03, 3'd0, 8'd11, 1'b1), 64'hA000, 64'hB000, {$urandom, $urandom});
        step(1'b1, p, 1'b1, 1'b1, acc);
        chk("mrst_accept", 224'(acc), 224'(1));
        step(1'b0, idle, 1'b1, 1'b0, acc);
        @(posedge clk);
        #3;
        chk("mrst_second_valid", 224'(out_valid), 224'(1));
        nreset = 1'b0;
        #1;
        chk("mrst_out_valid", 224'(out_valid), 224'(0));
        chk("mrst_in_ready", 224'(in_ready), 224'(0));
        exp_q.delete();
        reset_release();
        repeat (3) begin
            step(1'b0, idle, 1'b1, 1'b0, acc);
            chk("mrst_no_stale", 224'(out_valid), 224'(0));
        end

        // Randomized traffic against the reference model
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have && $urandom_range(0, 2) != 0) begin
                pend.cmd        = $urandom;
                pend.cmd[4:0]   = ops[$urandom_range(0, 6)];
                pend.cmd[7:5]   = 3'($urandom_range(0, 3));
                pend.cmd[15:8]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                pend.cmd[24]    = ($urandom_range(0, 7) == 0);
                pend.dst        = {$urandom, $urandom};
                pend.src        = {$urandom, $urandom};
                pend.data       = {$urandom, $urandom};
                have            = 1'b1;
            end
            step(have, have ? pend : idle, ($urandom_range(0, 3) != 0), 1'b1, acc);
            if (acc) have = 1'b0;
        end
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            step(1'b0, idle, 1'b1, 1'b1, acc);
            guard++;
        end
        chk("rand_drain_timeout", 224'(guard < 3000), 224'(1));
        chk("rand_q_empty", 224'(exp_q.size()), 224'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
